// File: rtl/run_ctrl.sv
// run_ctrl: program-run sequencer for the 8-bit core and its data memory.
// A rising edge on start holds the core in reset for RST_CYCLES cycles, then
// releases it and counts RUN cycles until the core reaches HALT_PC, the cycle
// limit expires, or the run is aborted. The data-memory port is handed to the
// core only while a run is in progress; otherwise the host/loader owns it.
// Every status output comes from a register, so there is no combinational
// path from pc to any output. The memory port mux is steered by the
// registered host_grant.
module run_ctrl #(
   parameter logic [7:0]  HALT_PC    = 8'hFF,
   parameter int unsigned RST_CYCLES = 32'd2,
   parameter int unsigned MAX_CYCLES = 32'd4096,
   parameter int unsigned CNT_W      = 32'd16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [7:0]       pc,
   input  logic             core_mem_we,
   input  logic [7:0]       core_mem_addr,
   input  logic [7:0]       core_mem_wdata,
   input  logic             host_mem_we,
   input  logic [7:0]       host_mem_addr,
   input  logic [7:0]       host_mem_wdata,
   output logic             core_rst,
   output logic             mem_we,
   output logic [7:0]       mem_addr,
   output logic [7:0]       mem_wdata,
   output logic             host_grant,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RST_HOLD = 2'd1,
      ST_RUN      = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   // The hold counter runs from RST_CYCLES-1 down to 0.
   localparam int unsigned     HOLD_W    = (RST_CYCLES > 32'd1) ? $clog2(RST_CYCLES) : 32'd1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_CYCLES - 32'd1);
   localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);

   // The limit is checked against the pre-increment count, so the last legal
   // value is MAX_CYCLES-1. If that value does not fit in CNT_W bits the
   // count saturates first and the limit can never match.
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LIMIT_LAST  = CNT_W'(MAX_CYCLES - 32'd1);
   localparam bit               LIMIT_REACH = (64'(MAX_CYCLES) - 64'd1) <= 64'(CNT_SAT);

   state_t              state_r;
   state_t              state_next_s;
   logic [HOLD_W-1:0]   hold_cnt_r;
   logic [HOLD_W-1:0]   hold_next_s;
   logic [CNT_W-1:0]    cycle_count_r;
   logic [CNT_W-1:0]    count_next_s;
   logic [CNT_W-1:0]    count_inc_s;
   logic                done_r;
   logic                done_next_s;
   logic                timeout_r;
   logic                timeout_next_s;
   logic                core_rst_r;
   logic                core_rst_next_s;
   logic                host_grant_r;
   logic                host_grant_next_s;
   logic                busy_r;
   logic                busy_next_s;
   logic                start_q_r;
   logic                start_edge_s;
   logic                halt_s;
   logic                limit_hit_s;

   assign start_edge_s = start & ~start_q_r;
   assign halt_s       = (pc == HALT_PC);
   assign limit_hit_s  = LIMIT_REACH && (cycle_count_r == LIMIT_LAST);

   // Saturating increment of the RUN cycle counter.
   always_comb begin
      count_inc_s = cycle_count_r;
      if (cycle_count_r != CNT_SAT) begin
         count_inc_s = cycle_count_r + CNT_ONE;
      end else begin
         count_inc_s = CNT_SAT;
      end
   end

   // State register plus all registered outputs and the start edge detector.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         hold_cnt_r    <= HOLD_ZERO;
         cycle_count_r <= CNT_ZERO;
         done_r        <= 1'b0;
         timeout_r     <= 1'b0;
         core_rst_r    <= 1'b1;
         host_grant_r  <= 1'b1;
         busy_r        <= 1'b0;
         start_q_r     <= 1'b0;
      end else begin
         state_r       <= state_next_s;
         hold_cnt_r    <= hold_next_s;
         cycle_count_r <= count_next_s;
         done_r        <= done_next_s;
         timeout_r     <= timeout_next_s;
         core_rst_r    <= core_rst_next_s;
         host_grant_r  <= host_grant_next_s;
         busy_r        <= busy_next_s;
         start_q_r     <= start;
      end
   end

   // Next-state and next-status decisions for the run sequence.
   always_comb begin
      state_next_s   = state_r;
      hold_next_s    = hold_cnt_r;
      count_next_s   = cycle_count_r;
      done_next_s    = done_r;
      timeout_next_s = timeout_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            // abort coincident with a start edge swallows the edge.
            if (start_edge_s && !abort) begin
               state_next_s   = ST_RST_HOLD;
               hold_next_s    = HOLD_LOAD;
               count_next_s   = CNT_ZERO;
               done_next_s    = 1'b0;
               timeout_next_s = 1'b0;
            end else begin
               state_next_s   = state_r;
            end
         end
         ST_RST_HOLD: begin
            if (abort) begin
               state_next_s   = ST_IDLE;
               done_next_s    = 1'b0;
               timeout_next_s = 1'b0;
            end else if (hold_cnt_r == HOLD_ZERO) begin
               state_next_s   = ST_RUN;
            end else begin
               hold_next_s    = hold_cnt_r - HOLD_ONE;
            end
         end
         ST_RUN: begin
            // Every RUN cycle is counted, including the one that ends the run.
            count_next_s = count_inc_s;
            if (abort) begin
               state_next_s   = ST_IDLE;
               done_next_s    = 1'b0;
               timeout_next_s = 1'b0;
            end else if (halt_s) begin
               state_next_s   = ST_DONE;
               done_next_s    = 1'b1;
               timeout_next_s = 1'b0;
            end else if (limit_hit_s) begin
               state_next_s   = ST_DONE;
               done_next_s    = 1'b1;
               timeout_next_s = 1'b1;
            end else begin
               state_next_s   = ST_RUN;
            end
         end
         default: begin
            state_next_s   = ST_IDLE;
            hold_next_s    = HOLD_ZERO;
            done_next_s    = 1'b0;
            timeout_next_s = 1'b0;
         end
      endcase
   end

   // Output decode from the upcoming state, captured by the state register.
   always_comb begin
      core_rst_next_s   = 1'b1;
      host_grant_next_s = 1'b1;
      busy_next_s       = 1'b0;
      case (state_next_s)
         ST_IDLE: begin
            core_rst_next_s   = 1'b1;
            host_grant_next_s = 1'b1;
            busy_next_s       = 1'b0;
         end
         ST_RST_HOLD: begin
            core_rst_next_s   = 1'b1;
            host_grant_next_s = 1'b0;
            busy_next_s       = 1'b1;
         end
         ST_RUN: begin
            core_rst_next_s   = 1'b0;
            host_grant_next_s = 1'b0;
            busy_next_s       = 1'b1;
         end
         ST_DONE: begin
            core_rst_next_s   = 1'b1;
            host_grant_next_s = 1'b1;
            busy_next_s       = 1'b0;
         end
         default: begin
            core_rst_next_s   = 1'b1;
            host_grant_next_s = 1'b1;
            busy_next_s       = 1'b0;
         end
      endcase
   end

   // Data-memory port mux; the ungranted side is simply dropped.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = 8'h00;
      mem_wdata = 8'h00;
      if (host_grant_r) begin
         mem_we    = host_mem_we;
         mem_addr  = host_mem_addr;
         mem_wdata = host_mem_wdata;
      end else begin
         mem_we    = core_mem_we;
         mem_addr  = core_mem_addr;
         mem_wdata = core_mem_wdata;
      end
   end

   assign core_rst    = core_rst_r;
   assign host_grant  = host_grant_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign timeout     = timeout_r;
   assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_run_ctrl.sv
// Testbench for run_ctrl: directed scenarios followed by random stimulus.
// Each cycle the stimulus process advances a behavioural model and queues the
// expected outputs; a monitor pops and compares one entry after every clock.
module tb_run_ctrl;

   localparam logic [7:0] HALT_PC    = 8'hFF;
   localparam int         RST_CYCLES = 2;
   localparam int         MAX_CYCLES = 8;
   localparam int         CNT_W      = 16;
   localparam int         CNT_MAX    = 65535;

   logic             clk = 1'b0;
   logic             rst, start, abort;
   logic [7:0]       pc;
   logic             core_mem_we, host_mem_we;
   logic [7:0]       core_mem_addr, core_mem_wdata, host_mem_addr, host_mem_wdata;
   logic             core_rst, mem_we, host_grant, busy, done, timeout;
   logic [7:0]       mem_addr, mem_wdata;
   logic [CNT_W-1:0] cycle_count;

   always #5 clk = ~clk;

   run_ctrl #(
      .HALT_PC   (HALT_PC),
      .RST_CYCLES(32'(RST_CYCLES)),
      .MAX_CYCLES(32'(MAX_CYCLES)),
      .CNT_W     (32'(CNT_W))
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .pc(pc),
      .core_mem_we(core_mem_we), .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata),
      .host_mem_we(host_mem_we), .host_mem_addr(host_mem_addr), .host_mem_wdata(host_mem_wdata),
      .core_rst(core_rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .host_grant(host_grant), .busy(busy), .done(done), .timeout(timeout),
      .cycle_count(cycle_count)
   );

   typedef struct packed {
      logic        core_rst;
      logic        host_grant;
      logic        busy;
      logic        done;
      logic        timeout;
      logic [15:0] count;
      logic        mem_we;
      logic [7:0]  mem_addr;
      logic [7:0]  mem_wdata;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model: a run is "active" from an accepted start edge; it is in
   // its RUN phase once RST_CYCLES cycles have elapsed since that edge.
   bit m_running    = 1'b0;
   int m_age        = 0;
   bit m_done       = 1'b0;
   bit m_to         = 1'b0;
   int m_count      = 0;
   bit m_prev_start = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic s, input logic a, input logic [7:0] p);
      bit edge_v;
      edge_v = s && !m_prev_start;
      if (r) begin
         m_running    = 1'b0;
         m_age        = 0;
         m_done       = 1'b0;
         m_to         = 1'b0;
         m_count      = 0;
         m_prev_start = 1'b0;
      end else begin
         if (m_running) begin
            if (m_age >= RST_CYCLES) begin
               if (m_count < CNT_MAX) m_count = m_count + 1;
               if (a) m_running = 1'b0;
               else if (p == HALT_PC) begin
                  m_running = 1'b0; m_done = 1'b1; m_to = 1'b0;
               end else if (m_count == MAX_CYCLES) begin
                  m_running = 1'b0; m_done = 1'b1; m_to = 1'b1;
               end
            end else if (a) begin
               m_running = 1'b0;
            end
            m_age = m_age + 1;
         end else if (edge_v && !a) begin
            m_running = 1'b1; m_age = 0; m_count = 0; m_done = 1'b0; m_to = 1'b0;
         end
         m_prev_start = s;
      end
   endtask

   // Drive one cycle of inputs, advance the model, queue the expectation.
   task automatic step(input logic r, input logic s, input logic a, input logic [7:0] p);
      exp_t e;
      rst = r; start = s; abort = a; pc = p;
      model_step(r, s, a, p);
      e.core_rst   = !(m_running && (m_age >= RST_CYCLES));
      e.host_grant = !m_running;
      e.busy       = m_running;
      e.done       = m_done;
      e.timeout    = m_to;
      e.count      = 16'(m_count);
      e.mem_we     = e.host_grant ? host_mem_we    : core_mem_we;
      e.mem_addr   = e.host_grant ? host_mem_addr  : core_mem_addr;
      e.mem_wdata  = e.host_grant ? host_mem_wdata : core_mem_wdata;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor: one queued expectation is due shortly after every clock edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("core_rst",    32'(core_rst),    32'(e.core_rst));
         chk("host_grant",  32'(host_grant),  32'(e.host_grant));
         chk("busy",        32'(busy),        32'(e.busy));
         chk("done",        32'(done),        32'(e.done));
         chk("timeout",     32'(timeout),     32'(e.timeout));
         chk("cycle_count", 32'(cycle_count), 32'(e.count));
         chk("mem_we",      32'(mem_we),      32'(e.mem_we));
         chk("mem_addr",    32'(mem_addr),    32'(e.mem_addr));
         chk("mem_wdata",   32'(mem_wdata),   32'(e.mem_wdata));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       s_v, a_v, r_v;
      logic [7:0] p_v;
      core_mem_we = 1'b0; core_mem_addr = 8'h00; core_mem_wdata = 8'h00;
      host_mem_we = 1'b0; host_mem_addr = 8'h00; host_mem_wdata = 8'h00;

      // Reset, then a host write while idle.
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      host_mem_we = 1'b1; host_mem_addr = 8'h10; host_mem_wdata = 8'hA5;
      step(1'b0, 1'b0, 1'b0, 8'h00);
      host_mem_we = 1'b0;

      // Halt on the 5th RUN cycle.
      step(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < RST_CYCLES; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b0, (i == 5) ? HALT_PC : 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      // Timeout after MAX_CYCLES RUN cycles.
      step(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < RST_CYCLES + MAX_CYCLES + 2; i++) step(1'b0, 1'b1, 1'b0, 8'h42);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      // Halt coinciding with the limit: halt wins.
      step(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < RST_CYCLES; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 1; i <= MAX_CYCLES; i++) step(1'b0, 1'b1, 1'b0, (i == MAX_CYCLES) ? HALT_PC : 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      // Both requesters write during RUN; a second start edge mid-run is ignored.
      step(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < RST_CYCLES; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      core_mem_we = 1'b1; core_mem_addr = 8'h20; core_mem_wdata = 8'h11;
      host_mem_we = 1'b1; host_mem_addr = 8'h30; host_mem_wdata = 8'h22;
      step(1'b0, 1'b0, 1'b0, 8'h01);
      step(1'b0, 1'b1, 1'b0, 8'h02);
      step(1'b0, 1'b1, 1'b0, 8'h03);
      core_mem_we = 1'b0; host_mem_we = 1'b0;
      step(1'b0, 1'b0, 1'b0, HALT_PC);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      // Abort on the 3rd RUN cycle.
      step(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < RST_CYCLES; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b1, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      // Abort together with a start edge in IDLE: no run.
      step(1'b0, 1'b1, 1'b1, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      // Finish a run, start another, reset mid-run with start held high.
      step(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < RST_CYCLES; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, HALT_PC);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < RST_CYCLES + 2; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < RST_CYCLES + 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, HALT_PC);

      // Random traffic.
      s_v = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) s_v = ~s_v;
         a_v = ($urandom_range(0, 39) == 0);
         r_v = ($urandom_range(0, 249) == 0);
         p_v = ($urandom_range(0, 11) == 0) ? HALT_PC : 8'($urandom_range(0, 254));
         core_mem_we    = 1'($urandom_range(0, 1));
         core_mem_addr  = 8'($urandom_range(0, 255));
         core_mem_wdata = 8'($urandom_range(0, 255));
         host_mem_we    = 1'($urandom_range(0, 1));
         host_mem_addr  = 8'($urandom_range(0, 255));
         host_mem_wdata = 8'($urandom_range(0, 255));
         step(r_v, s_v, a_v, p_v);
      end

      @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Program-run sequencer for the 8-bit core and its data memory.
- Turns a start edge into a timed core-reset pulse, runs the core, and detects halt (PC == HALT_PC) or cycle timeout.
- Raises done, reports the cycle count, and arbitrates the data-memory write/address port between the core (while running) and a host/loader (while idle or done).
- Sits between the top level and the core/dmem instances, replacing the ad-hoc rst|~start and pc==8'hFF logic.

Parameters:
- HALT_PC, 8'hFF, PC value that signals program completion.
- RST_CYCLES, 2, cycles the core is held in reset after a start edge (>=1).
- MAX_CYCLES, 16'd4096, RUN-cycle limit before timeout (>=1).
- CNT_W, 16, width of cycle_count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; a 0->1 transition requests a run.
- abort  input  1  level; cancels an in-progress run.
- pc  input  8  core program counter.
- core_mem_we  input  1  core data-memory write enable.
- core_mem_addr  input  8  core data-memory address (ALUOut).
- core_mem_wdata  input  8  core data-memory write data (SrcA).
- host_mem_we  input  1  host/loader write enable.
- host_mem_addr  input  8  host/loader address.
- host_mem_wdata  input  8  host/loader write data.
- core_rst  output  1  reset to core; 1 except in RUN.
- mem_we  output  1  muxed write enable to dmem.
- mem_addr  output  8  muxed address to dmem.
- mem_wdata  output  8  muxed write data to dmem.
- host_grant  output  1  1 = host owns dmem port.
- busy  output  1  1 in RST_HOLD or RUN.
- done  output  1  run finished (halt or timeout); sticky.
- timeout  output  1  run ended by MAX_CYCLES limit; sticky with done.
- cycle_count  output  CNT_W  RUN cycles of the current/last run.

Behaviour:
- Reset (rst=1 at clk edge), all registers: state=IDLE, core_rst=1, host_grant=1, busy=0, done=0, timeout=0, cycle_count=0, start_q=0, hold counter=0. Reset wins over every other event in any state.
- Edge detect: start_q <= start each cycle; start_edge = start & ~start_q. Because start_q resets to 0, a start held high across reset deassertion produces an edge on the first post-reset cycle.
- States: IDLE, RST_HOLD, RUN, DONE. All outputs are registered or decoded from registered state only; no combinational path from pc.
- IDLE:
  - core_rst=1, host_grant=1.
  - start_edge -> RST_HOLD: load hold counter=RST_CYCLES-1, clear cycle_count, done and timeout.
- RST_HOLD:
  - core_rst=1, host_grant=0, busy=1.
  - Counter decrements each cycle; at 0 -> RUN.
  - Total cycles in RST_HOLD = RST_CYCLES.
- RUN:
  - core_rst=0, host_grant=0, busy=1.
  - Each cycle cycle_count <= cycle_count+1. Transition decisions use the pre-increment value.
  - pc==HALT_PC -> DONE with done=1, timeout=0.
  - Else cycle_count==MAX_CYCLES-1 -> DONE with done=1, timeout=1.
  - Halt and limit in the same cycle: halt wins (timeout=0).
  - Final cycle_count = number of cycles spent in RUN, inclusive of the halting cycle.
- DONE:
  - core_rst=1 (core frozen), host_grant=1, busy=0.
  - done, timeout and cycle_count hold until the next start_edge, which behaves as in IDLE.
- abort=1 in RST_HOLD or RUN -> IDLE next cycle: core_rst=1, host_grant=1, done=0, timeout=0, cycle_count holds its value. abort is ignored in IDLE/DONE. abort and start_edge in the same cycle: abort wins, and the edge is consumed (no run).
- start_edge in RST_HOLD or RUN is ignored.
- Memory mux, combinational from registered host_grant:
  - host_grant=1: mem_* = host_mem_*.
  - host_grant=0: mem_* = core_mem_*.
  - The ungranted requester's writes are dropped; there is no queuing.
- cycle_count saturates at all-ones if MAX_CYCLES >= 2^CNT_W; there is no wrap.

Test Plan:
- Reset then idle, host writes addr 8'h10 data 8'hA5 -> mem_we=1, mem_addr=8'h10, mem_wdata=8'hA5, core_rst=1, host_grant=1, done=0.
- Start edge with RST_CYCLES=2, pc reaches 8'hFF on the 5th RUN cycle -> core_rst high exactly 2 cycles after the edge, then low 5 cycles; done=1, timeout=0, cycle_count=5 on the following cycle; core_rst=1 and host_grant=1 thereafter.
- MAX_CYCLES=8, pc never 8'hFF -> DONE after 8 RUN cycles, done=1, timeout=1, cycle_count=8. Variant with pc=8'hFF on the 8th RUN cycle -> timeout=0.
- During RUN, core_mem_we=1 addr 8'h20 and host_mem_we=1 addr 8'h30 -> mem_addr=8'h20, host write dropped; second start edge mid-RUN has no effect.
- abort on the 3rd RUN cycle -> IDLE next cycle, done=0, core_rst=1, host_grant=1, cycle_count=3. abort coincident with a start edge in IDLE -> stays IDLE.
- rst asserted mid-RUN with done previously 1 -> all outputs at reset values next cycle. start held high through reset -> run begins (RST_HOLD) on the first post-reset cycle.
